mips_cpu_control_fsm: RTL

Multi-cycle control unit for the MIPS CPU; next generation of the single-cycle opcode decoder. It holds a per-instruction state machine (fetch, decode, execute, memory, writeback, multiply/divide wait, halt) and drives datapath strobes per state. Memory is stalled by a wait-request handshake, and mult/div completion comes from an internal countdown. It sits between the instruction register and the shared memory-mapped datapath; decoding is extended to `xori`, `lui` and the mult/div family.

---
 rtl/mips_cpu_pkg.sv | 48 ++++
 rtl/mips_cpu_decode.sv | 84 ++++++++
 rtl/mips_cpu_control_fsm.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, instruction
// fields, ALU operation codes and the decoded control bundle.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_MULDIV, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_MULDIV, CLS_BRANCH, CLS_JUMP
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J     = 6'b000010,
                           OP_JAL   = 6'b000011, OP_BEQ    = 6'b000100, OP_BNE   = 6'b000101,
                           OP_BLEZ  = 6'b000110, OP_BGTZ   = 6'b000111, OP_ADDIU = 6'b001001,
                           OP_SLTI  = 6'b001010, OP_SLTIU  = 6'b001011, OP_ANDI  = 6'b001100,
                           OP_ORI   = 6'b001101, OP_XORI   = 6'b001110, OP_LUI   = 6'b001111,
                           OP_LW    = 6'b100011, OP_SW     = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL   = 6'b000010, F_SRA  = 6'b000011,
                           F_SLLV = 6'b000100, F_SRLV  = 6'b000110, F_SRAV = 6'b000111,
                           F_JR   = 6'b001000, F_JALR  = 6'b001001, F_MFHI = 6'b010000,
                           F_MTHI = 6'b010001, F_MFLO  = 6'b010010, F_MTLO = 6'b010011,
                           F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV  = 6'b011010,
                           F_DIVU = 6'b011011, F_ADDU  = 6'b100001, F_SUBU = 6'b100011,
                           F_AND  = 6'b100100, F_OR    = 6'b100101, F_XOR  = 6'b100110,
                           F_NOR  = 6'b100111, F_SLT   = 6'b101010, F_SLTU = 6'b101011;

    localparam logic [4:0] RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001,
                           RT_BLTZAL = 5'b10000, RT_BGEZAL = 5'b10001;

    localparam logic [3:0] ALU_RTYPE = 4'b0000, ALU_ADD = 4'b0001, ALU_AND  = 4'b0010,
                           ALU_EQ    = 4'b0011, ALU_GTZ = 4'b0100, ALU_GEZ  = 4'b0101,
                           ALU_LTZ   = 4'b0110, ALU_LEZ = 4'b0111, ALU_NE   = 4'b1000,
                           ALU_OR    = 4'b1001, ALU_SLTI = 4'b1010, ALU_SLTIU = 4'b1011,
                           ALU_XOR   = 4'b1100, ALU_LUI = 4'b1101;

    typedef struct packed {
        instr_class_t cls;
        logic [3:0]   aluop;
        logic         alusrc;
        logic         regdst;
        logic         signed_data;
        logic         link;
        logic         halt_able;   // j/jr/jalr may stop the core on a zero target
    } ctrl_t;

endpackage

// File: rtl/mips_cpu_decode.sv
// Combinational instruction classifier: IR fields to class plus the static
// controls that stay constant for the whole instruction.
module mips_cpu_decode
    import mips_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] branch_type,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MTHI, F_MFLO,
                    F_MTLO, F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        ctrl.cls    = CLS_ALU_R;
                        ctrl.regdst = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl.cls = CLS_MULDIV;
                    F_JR: begin
                        ctrl.cls       = CLS_JUMP;
                        ctrl.halt_able = 1'b1;
                    end
                    F_JALR: begin
                        ctrl.cls       = CLS_JUMP;
                        ctrl.link      = 1'b1;
                        ctrl.regdst    = 1'b1;
                        ctrl.halt_able = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                ctrl.cls         = CLS_BRANCH;
                ctrl.signed_data = 1'b1;
                case (branch_type)
                    RT_BLTZ:   ctrl.aluop = ALU_LTZ;
                    RT_BGEZ:   ctrl.aluop = ALU_GEZ;
                    RT_BLTZAL: begin ctrl.aluop = ALU_LTZ; ctrl.link = 1'b1; end
                    RT_BGEZAL: begin ctrl.aluop = ALU_GEZ; ctrl.link = 1'b1; end
                    default:   ctrl = '0;
                endcase
            end
            OP_J:   begin ctrl.cls = CLS_JUMP; ctrl.halt_able = 1'b1; end
            OP_JAL: begin ctrl.cls = CLS_JUMP; ctrl.link = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                ctrl.cls         = CLS_BRANCH;
                ctrl.signed_data = 1'b1;
                case (opcode)
                    OP_BEQ:  ctrl.aluop = ALU_EQ;
                    OP_BNE:  ctrl.aluop = ALU_NE;
                    OP_BLEZ: ctrl.aluop = ALU_LEZ;
                    default: ctrl.aluop = ALU_GTZ;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.cls    = CLS_ALU_I;
                ctrl.alusrc = 1'b1;
                // Logical immediates and lui are zero-extended.
                ctrl.signed_data = (opcode == OP_ADDIU) || (opcode == OP_SLTI) || (opcode == OP_SLTIU);
                case (opcode)
                    OP_ADDIU: ctrl.aluop = ALU_ADD;
                    OP_SLTI:  ctrl.aluop = ALU_SLTI;
                    OP_SLTIU: ctrl.aluop = ALU_SLTIU;
                    OP_ANDI:  ctrl.aluop = ALU_AND;
                    OP_ORI:   ctrl.aluop = ALU_OR;
                    OP_XORI:  ctrl.aluop = ALU_XOR;
                    default:  ctrl.aluop = ALU_LUI;
                endcase
            end
            OP_LW, OP_SW: begin
                ctrl.cls         = (opcode == OP_LW) ? CLS_LOAD : CLS_STORE;
                ctrl.aluop       = ALU_ADD;
                ctrl.alusrc      = 1'b1;
                ctrl.signed_data = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle MIPS control FSM: per-instruction state sequence, mult/div
// countdown and per-state gating of the decoded controls.
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = $clog2(MULDIV_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] branch_type,
    input  logic       mem_waitrequest,
    input  logic       halt_req,
    output logic       active,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrc,
    output logic       branch,
    output logic       jump,
    output logic       link,
    output logic       signed_data,
    output logic       hilo_write,
    output logic       iord,
    output logic [3:0] aluop
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    ctrl_t            ctrl;

    mips_cpu_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .branch_type (branch_type),
        .ctrl        (ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        active      = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        regwrite    = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrc      = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        link        = 1'b0;
        signed_data = 1'b0;
        hilo_write  = 1'b0;
        iord        = 1'b0;
        aluop       = ALU_RTYPE;
        // Outputs are forced low for the whole reset pulse, not just after the edge.
        if (!reset) begin
            active = (state_reg != ST_HALT);
            case (state_reg)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = !mem_waitrequest;
                    pc_write = !mem_waitrequest;
                    if (!mem_waitrequest) state_next = ST_DECODE;
                end
                ST_DECODE: state_next = ST_EXEC;
                ST_EXEC: begin
                    aluop       = ctrl.aluop;
                    alusrc      = ctrl.alusrc;
                    regdst      = ctrl.regdst;
                    signed_data = ctrl.signed_data;
                    case (ctrl.cls)
                        CLS_ALU_R, CLS_ALU_I: state_next = ST_WB;
                        CLS_LOAD, CLS_STORE:  state_next = ST_MEM;
                        CLS_MULDIV: begin
                            state_next = ST_MULDIV;
                            cnt_next   = CNT_LOAD;
                        end
                        CLS_BRANCH: begin
                            branch     = 1'b1;
                            link       = ctrl.link;
                            regwrite   = ctrl.link;
                            state_next = ST_FETCH;
                        end
                        CLS_JUMP: begin
                            jump       = 1'b1;
                            link       = ctrl.link;
                            regwrite   = ctrl.link;
                            state_next = (ctrl.halt_able && halt_req) ? ST_HALT : ST_FETCH;
                        end
                        default: state_next = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    iord      = 1'b1;
                    mem_read  = (ctrl.cls == CLS_LOAD);
                    mem_write = (ctrl.cls == CLS_STORE);
                    if (!mem_waitrequest) state_next = (ctrl.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
                ST_WB: begin
                    regwrite   = 1'b1;
                    memtoreg   = (ctrl.cls == CLS_LOAD);
                    regdst     = ctrl.regdst;
                    state_next = ST_FETCH;
                end
                ST_MULDIV: begin
                    if (cnt_reg == '0) begin
                        hilo_write = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                ST_HALT: ;
                default: state_next = ST_FETCH;
            endcase
        end
    end

endmodule
